// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the multi-port register file.
package reg_file_pkg;
   typedef enum logic {CLEAR, RUN} state_t;

   localparam int DEF_WORD_SIZE = 16;
   localparam int DEF_REG_NUM   = 8;
   localparam int DEF_ADDR_W    = 3;
endpackage

// File: rtl/reg_file_mp_read_port.sv
// One buffered read port: range/zero check, write-first bypass, operand and pending registers.
module reg_read_port
   import reg_file_pkg::*;
#(
   parameter int WORD_SIZE = DEF_WORD_SIZE,
   parameter int REG_NUM   = DEF_REG_NUM,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int ZERO_R0   = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [ADDR_W-1:0]    addr,
   input  logic                 wr_en,
   input  logic [ADDR_W-1:0]    wr_addr,
   input  logic [WORD_SIZE-1:0] wr_data,
   input  logic [WORD_SIZE-1:0] rd_data,
   input  logic [REG_NUM-1:0]   pend_vec,
   output logic [WORD_SIZE-1:0] reg_buff,
   output logic                 pend
);
   logic                 in_range;
   logic [WORD_SIZE-1:0] load_data;
   logic                 load_pend;

   assign in_range = (int'(addr) < REG_NUM) && !((ZERO_R0 != 0) && (addr == '0));

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      load_data = '0;
      load_pend = 1'b0;
      if (in_range) begin
         load_data = (wr_en && (wr_addr == addr)) ? wr_data : rd_data;
         load_pend = pend_vec[addr];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         reg_buff <= '0;
         pend     <= 1'b0;
      end else if (load) begin
         reg_buff <= load_data;
         pend     <= load_pend;
      end
   end
endmodule

// File: rtl/reg_file_mp.sv
// Register file with one write port, two buffered read ports, post-reset clearing sweep and pending bits.
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int WORD_SIZE = DEF_WORD_SIZE,
   parameter int REG_NUM   = DEF_REG_NUM,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int ZERO_R0   = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 write,
   input  logic [ADDR_W-1:0]    addr_in,
   input  logic [WORD_SIZE-1:0] data_in,
   input  logic [ADDR_W-1:0]    addr1,
   input  logic [ADDR_W-1:0]    addr2,
   input  logic                 write_buff1,
   input  logic                 write_buff2,
   input  logic                 pend_set,
   input  logic [ADDR_W-1:0]    pend_addr,
   output logic [WORD_SIZE-1:0] reg_buff1,
   output logic [WORD_SIZE-1:0] reg_buff2,
   output logic                 pend1,
   output logic                 pend2,
   output logic                 ready
);
   state_t               state, state_next;
   logic [ADDR_W-1:0]    idx, idx_next;
   logic [WORD_SIZE-1:0] mem [REG_NUM];
   logic [REG_NUM-1:0]   pend_q, pend_next;
   logic                 run, write_ok, pend_ok;

   assign run      = (state == RUN) && !rst;
   assign write_ok = run && write && (int'(addr_in) < REG_NUM)
                     && !((ZERO_R0 != 0) && (addr_in == '0));
   assign pend_ok  = run && pend_set && (int'(pend_addr) < REG_NUM);
   assign ready    = (state == RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
         idx   <= '0;
      end else begin
         state <= state_next;
         idx   <= idx_next;
      end
   end

   always_comb begin
      state_next = state;
      idx_next   = idx;
      if (state == CLEAR) begin
         if (idx == ADDR_W'(REG_NUM - 1)) begin
            state_next = RUN;
            idx_next   = '0;
         end else begin
            idx_next = idx + 1'b1;
         end
      end
   end

   // A same-edge pend_set wins over the clear from a write to the same register.
   always_comb begin
      pend_next = pend_q;
      if (write_ok) pend_next[addr_in]   = 1'b0;
      if (pend_ok)  pend_next[pend_addr] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) pend_q <= '0;
      else     pend_q <= pend_next;
   end

   // NOTE: the storage array has no reset; the CLEAR sweep zeroes it one entry per cycle instead.
   always_ff @(posedge clk) begin
      if (!rst && (state == CLEAR)) mem[idx] <= '0;
      else if (write_ok)            mem[addr_in] <= data_in;
   end

   reg_read_port #(
      .WORD_SIZE(WORD_SIZE), .REG_NUM(REG_NUM), .ADDR_W(ADDR_W), .ZERO_R0(ZERO_R0)
   ) u_port1 (
      .clk      (clk),
      .rst      (rst),
      .load     (run && write_buff1),
      .addr     (addr1),
      .wr_en    (write_ok),
      .wr_addr  (addr_in),
      .wr_data  (data_in),
      .rd_data  (mem[addr1]),
      .pend_vec (pend_next),
      .reg_buff (reg_buff1),
      .pend     (pend1)
   );

   reg_read_port #(
      .WORD_SIZE(WORD_SIZE), .REG_NUM(REG_NUM), .ADDR_W(ADDR_W), .ZERO_R0(ZERO_R0)
   ) u_port2 (
      .clk      (clk),
      .rst      (rst),
      .load     (run && write_buff2),
      .addr     (addr2),
      .wr_en    (write_ok),
      .wr_addr  (addr_in),
      .wr_data  (data_in),
      .rd_data  (mem[addr2]),
      .pend_vec (pend_next),
      .reg_buff (reg_buff2),
      .pend     (pend2)
   );
endmodule

// File: tb/tb_reg_file_mp.sv
// Randomized and directed bench for reg_file_mp: two instances (full 8-entry, and 6-entry with zero r0).
module tb_reg_file_mp;
   localparam int W  = 16;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst, write, write_buff1, write_buff2, pend_set;
   logic [AW-1:0] addr_in, addr1, addr2, pend_addr;
   logic [W-1:0]  data_in;

   logic [W-1:0]  b1 [2];
   logic [W-1:0]  b2 [2];
   logic          p1 [2];
   logic          p2 [2];
   logic          rdy [2];

   always #5 clk = ~clk;

   reg_file_mp #(.WORD_SIZE(W), .REG_NUM(8), .ADDR_W(AW), .ZERO_R0(0)) u_dut0 (
      .clk(clk), .rst(rst), .write(write), .addr_in(addr_in), .data_in(data_in),
      .addr1(addr1), .addr2(addr2), .write_buff1(write_buff1), .write_buff2(write_buff2),
      .pend_set(pend_set), .pend_addr(pend_addr),
      .reg_buff1(b1[0]), .reg_buff2(b2[0]), .pend1(p1[0]), .pend2(p2[0]), .ready(rdy[0])
   );

   reg_file_mp #(.WORD_SIZE(W), .REG_NUM(6), .ADDR_W(AW), .ZERO_R0(1)) u_dut1 (
      .clk(clk), .rst(rst), .write(write), .addr_in(addr_in), .data_in(data_in),
      .addr1(addr1), .addr2(addr2), .write_buff1(write_buff1), .write_buff2(write_buff2),
      .pend_set(pend_set), .pend_addr(pend_addr),
      .reg_buff1(b1[1]), .reg_buff2(b2[1]), .pend1(p1[1]), .pend2(p2[1]), .ready(rdy[1])
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Reference model: architectural contents, pending flags and sweep progress per instance.
   logic [W-1:0] m_mem  [2][8];
   logic [7:0]   m_pend [2];
   logic [W-1:0] m_b1 [2];
   logic [W-1:0] m_b2 [2];
   bit           m_p1 [2];
   bit           m_p2 [2];
   int           m_cnt [2];

   function automatic int rn_of(input int k);
      return (k == 0) ? 8 : 6;
   endfunction

   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         int         rn;
         bit         z, wok, pok, valid, wb;
         logic [7:0] np;
         int         a;
         logic [W-1:0] val;
         bit         pv;
         rn = rn_of(k);
         z  = (k == 1);
         if (rst) begin
            m_cnt[k] = 0; m_pend[k] = '0;
            m_b1[k] = '0; m_b2[k] = '0; m_p1[k] = 0; m_p2[k] = 0;
         end else if (m_cnt[k] < rn) begin
            m_mem[k][m_cnt[k]] = '0;
            m_cnt[k]++;
         end else begin
            wok = write && (int'(addr_in) < rn) && !(z && addr_in == 0);
            pok = pend_set && (int'(pend_addr) < rn);
            np = m_pend[k];
            if (wok) np[addr_in] = 1'b0;
            if (pok) np[pend_addr] = 1'b1;
            for (int p = 0; p < 2; p++) begin
               a  = (p == 0) ? int'(addr1) : int'(addr2);
               wb = (p == 0) ? write_buff1 : write_buff2;
               valid = (a < rn) && !(z && a == 0);
               val = '0;
               pv  = 0;
               if (valid) begin
                  val = (wok && int'(addr_in) == a) ? data_in : m_mem[k][a];
                  pv  = np[a];
               end
               if (wb && p == 0) begin m_b1[k] = val; m_p1[k] = pv; end
               if (wb && p == 1) begin m_b2[k] = val; m_p2[k] = pv; end
            end
            if (wok) m_mem[k][addr_in] = data_in;
            m_pend[k] = np;
         end
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("ready%0d", k), 32'(rdy[k]), 32'(m_cnt[k] >= rn_of(k)));
         check($sformatf("buff1_%0d", k), 32'(b1[k]), 32'(m_b1[k]));
         check($sformatf("buff2_%0d", k), 32'(b2[k]), 32'(m_b2[k]));
         check($sformatf("pend1_%0d", k), 32'(p1[k]), 32'(m_p1[k]));
         check($sformatf("pend2_%0d", k), 32'(p2[k]), 32'(m_p2[k]));
      end
   endtask

   task automatic idle();
      write = 0; write_buff1 = 0; write_buff2 = 0; pend_set = 0;
      addr_in = '0; addr1 = '0; addr2 = '0; pend_addr = '0; data_in = '0;
   endtask

   task automatic do_write(input int a, input logic [W-1:0] d);
      idle(); write = 1; addr_in = AW'(a); data_in = d; step();
   endtask

   task automatic load2(input int a);
      idle(); write_buff2 = 1; addr2 = AW'(a); step();
   endtask

   initial begin
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 8; i++) m_mem[k][i] = '0;
      idle();
      rst = 1;
      step();
      rst = 0;

      repeat (7) step();
      check("ready_before_sweep_end", 32'(rdy[0]), 32'd0);
      step();
      check("ready_after_8_edges", 32'(rdy[0]), 32'd1);

      for (int a = 0; a < 8; a++) begin
         idle(); write_buff1 = 1; write_buff2 = 1; addr1 = AW'(a); addr2 = AW'(7 - a); step();
         check("cleared_read", 32'(b1[0]), 32'd0);
      end

      do_write(3, 16'h1234);
      idle(); write_buff1 = 1; addr1 = 3; step();
      check("write_then_read", 32'(b1[0]), 32'h1234);

      idle(); write = 1; addr_in = 5; data_in = 16'hBEEF;
      write_buff1 = 1; write_buff2 = 1; addr1 = 5; addr2 = 5; step();
      check("bypass_port1", 32'(b1[0]), 32'hBEEF);
      check("bypass_port2", 32'(b2[0]), 32'hBEEF);
      check("bypass_port2_z", 32'(b2[1]), 32'hBEEF);

      do_write(0, 16'hFFFF);
      idle(); write_buff1 = 1; addr1 = 0; step();
      check("zero_r0_value", 32'(b1[1]), 32'd0);
      check("zero_r0_pend", 32'(p1[1]), 32'd0);
      check("plain_r0_value", 32'(b1[0]), 32'hFFFF);

      idle(); pend_set = 1; pend_addr = 2; step();
      load2(2);
      check("pend_set_seen", 32'(p2[0]), 32'd1);
      do_write(2, 16'h0042);
      load2(2);
      check("pend_cleared_by_write", 32'(p2[0]), 32'd0);
      idle(); pend_set = 1; pend_addr = 2; write = 1; addr_in = 2; data_in = 16'h0077; step();
      load2(2);
      check("pend_set_wins", 32'(p2[0]), 32'd1);

      do_write(1, 16'hAAAA);
      idle(); rst = 1; step();
      rst = 0;
      check("ready_drops", 32'(rdy[0]), 32'd0);
      for (int i = 0; i < 20 && !rdy[0]; i++) begin
         idle(); write_buff1 = 1; addr1 = 1; step();
      end
      check("ready_returns", 32'(rdy[0]), 32'd1);
      idle(); write_buff1 = 1; addr1 = 1; step();
      check("r1_cleared_after_reset", 32'(b1[0]), 32'd0);

      for (int i = 0; i < 3000; i++) begin
         rst         = ($urandom_range(0, 199) == 0);
         write       = $urandom_range(0, 1);
         addr_in     = AW'($urandom_range(0, 7));
         data_in     = W'($urandom);
         addr1       = AW'($urandom_range(0, 7));
         addr2       = AW'($urandom_range(0, 7));
         write_buff1 = $urandom_range(0, 1);
         write_buff2 = $urandom_range(0, 1);
         pend_set    = ($urandom_range(0, 3) == 0);
         pend_addr   = AW'($urandom_range(0, 7));
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised successor register file for the CPU datapath: one write port and two buffered read ports, with configurable word size and depth. Adds write-to-read bypass, an optional hard-wired zero register, a post-reset clearing sweep with a ready flag, and per-register pending bits for hazard tracking. Sits between the decode stage, which loads the operand buffers, and writeback, which drives the write port.

## Interface
- WORD_SIZE, 16, data width in bits
- REG_NUM, 8, number of architectural registers (≥2)
- ADDR_W, 3, address width; must satisfy 2**ADDR_W ≥ REG_NUM
- ZERO_R0, 0, when 1 register 0 reads as zero and ignores writes

- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- write  in  1  write enable
- addr_in  in  ADDR_W  write address
- data_in  in  WORD_SIZE  write data
- addr1, addr2  in  ADDR_W  read addresses, ports 1/2
- write_buff1, write_buff2  in  1  load enable for reg_buff1/reg_buff2
- pend_set  in  1  mark register pend_addr as awaiting a result
- pend_addr  in  ADDR_W  register to mark pending
- reg_buff1, reg_buff2  out  WORD_SIZE  registered operand buffers
- pend1, pend2  out  1  registered pending status of the register captured into reg_buff1/2
- ready  out  1  high once the clearing sweep has finished

## Operation
- Two states: CLEAR, RUN. rst forces CLEAR with sweep index idx=0; reg_buff1/2=0, pend1/2=0, all pending bits=0, ready=0.
- CLEAR, rst low: each edge writes 0 to reg_file[idx] and increments idx; on the edge that writes idx=REG_NUM-1, go to RUN. write, pend_set, write_buff1/2 are ignored in CLEAR.
- RUN: ready=1. If write is high and addr_in < REG_NUM (and addr_in≠0 when ZERO_R0), reg_file[addr_in] ← data_in, and that register's pending bit clears.
- pend_set with pend_addr < REG_NUM sets the bit. If pend_set and write target the same address on the same edge, set wins and the bit stays 1.
- Read port n, write_buffn high: reg_buffn ← bypass value; pendn ← the pending bit after the same-edge update. Otherwise reg_buffn and pendn hold.
- Bypass: if write is accepted and addr_in==addrn on the same edge, the buffer takes data_in (write-first). Otherwise it takes reg_file[addrn].
- addrn ≥ REG_NUM, or addrn==0 with ZERO_R0: the buffer loads 0 and pendn loads 0.
- Writes to out-of-range addresses, or to r0 when ZERO_R0, are dropped silently.

## Timing
- Read latency is 1 cycle: reg_buffn is valid after the edge on which write_buffn was sampled high.
- Write to read, different cycles: a write at edge k is visible to a load at edge k+1. Same edge: visible through the bypass.
- ready rises after exactly REG_NUM rising edges with rst low after reset release.
- rst asserted mid-sweep or in RUN restarts the sweep from idx 0. Register contents not yet reswept keep stale values but are unreadable, since loads are ignored in CLEAR.
- Both ports may load the same address on the same edge; each gets an identical result.

## Structure
- Package reg_file_pkg: state enum {CLEAR, RUN}, default WORD_SIZE and REG_NUM constants.
- Sub-module reg_read_port, instantiated twice. It contains the address range/zero check, the bypass mux, and the reg_buffn/pendn registers.
- Top level holds the storage array, the sweep FSM and counter, and the pending bit vector.

## Test plan
- Reset sweep: REG_NUM=8, release rst. ready is 0 for 8 edges and 1 on the 9th cycle; loading any address then returns 0.
- Write/read: write r3=0x1234, next cycle write_buff1 with addr1=3. reg_buff1=0x1234 one cycle later, and reg_buff2 is unchanged.
- Bypass: write r5=0xBEEF with addr1=addr2=5 and both loads on the same edge. Both buffers read 0xBEEF.
- ZERO_R0=1: write r0=0xFFFF, then load addr1=0. reg_buff1=0, pend1=0.
- Pending: pend_set r2, then load addr2=2 gives pend2=1. A write to r2 followed by a load gives pend2=0. pend_set r2 together with a write to r2 leaves pend2=1 on the next load.
- Mid-operation reset: write r1=0xAAAA, then assert rst for 1 cycle during RUN. ready drops, and loads are ignored until ready returns. Loading r1 afterwards returns 0.
